// File: rtl/ropuf_response_evaluator.sv
// ropuf_response_evaluator
// Sequences the RO-PUF challenge schedule (round/count + chal_strobe), measures
// the two ring oscillators selected by chal_in over a per-bit window, and
// shifts the comparison result of each bit into the key register.
// Optional build macro: ROPUF_MAJORITY_VOTE_EN splits the measurement window
// into three sub-windows and shifts the majority of the three sub-results.
// Handshake: start is a one-cycle request, accepted only in IDLE or DONE.
// key is valid while key_valid is high. chal_strobe is a one-clock pulse, and
// chal_in must then hold steady from count 10 through 25 of the bit.
module ropuf_response_evaluator #(
    parameter int KEY_BITS = 128,
    parameter int TICK_DIV = 64,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [7:0]          chal_in,
    input  logic [15:0]         ro_in,
    output logic [3:0]          round,
    output logic [4:0]          count,
    output logic                chal_strobe,
    output logic [KEY_BITS-1:0] key,
    output logic                key_valid,
    output logic                busy,
    output logic [7:0]          tie_cnt
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [8:0]      LAST_BIT   = 9'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   presc;
    logic [8:0]      bit_idx;
    logic            run;
    logic            go;
    logic            tick;
    logic            first;
    logic            wrap;
    logic            last_wrap;

    logic [15:0]     sync1;
    logic [15:0]     sync2;
    logic [15:0]     sync_prev;
    logic [15:0]     ro_edge;
    logic            edge_a;
    logic            edge_b;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic            cnt_clear;
    logic            cnt_en;
    logic            sub_restart;
    logic            gt;
    logic            eq;
    logic            shift_now;
    logic            res_bit;
    logic            res_tie;

    assign run       = (state == S_RUN);
    assign go        = start && (state != S_RUN);
    assign tick      = run && (presc == PRESC_LAST);
    assign first     = run && (presc == '0);
    assign wrap      = tick && (count == 5'd31);
    assign last_wrap = wrap && (bit_idx == LAST_BIT);
    assign round     = bit_idx[7:4];

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state: start is ignored while a run is in progress
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_wrap) state_next = S_DONE;
            S_DONE:  if (start) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered status outputs, aligned with the state register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            busy      <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            busy      <= (state_next == S_RUN);
            key_valid <= (state_next == S_DONE);
        end
    end

    // Prescaler, step counter and bit index; all restart on an accepted start
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            presc   <= '0;
            count   <= '0;
            bit_idx <= '0;
        end else if (go) begin
            presc   <= '0;
            count   <= '0;
            bit_idx <= '0;
        end else if (run) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) count <= count + 5'd1;
            if (wrap) bit_idx <= last_wrap ? 9'd0 : bit_idx + 9'd1;
        end
    end

    // Challenge strobe lands on the first clock of count 5 (bit 0) or 26 (later bits)
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) chal_strobe <= 1'b0;
        else       chal_strobe <= tick && (((bit_idx == 9'd0) && (count == 5'd4)) ||
                                           ((bit_idx != 9'd0) && (count == 5'd25)));
    end

    // Two-flop synchronizer plus previous-value flop for rising-edge detection
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
        end else begin
            sync1     <= ro_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign ro_edge   = sync2 & ~sync_prev;
    assign edge_a    = ro_edge[chal_in[7:4]];
    assign edge_b    = ro_edge[chal_in[3:0]];
    assign cnt_clear = !run || (count < 5'd10);
    assign cnt_en    = run && (count >= 5'd10) && (count <= 5'd24);
    assign gt        = (cnt_a > cnt_b);
    assign eq        = (cnt_a == cnt_b);
    assign shift_now = first && (count == 5'd25);

`ifdef ROPUF_MAJORITY_VOTE_EN
    logic [1:0] sub_gt;
    logic [1:0] sub_eq;

    assign sub_restart = first && ((count == 5'd15) || (count == 5'd20));
    assign res_bit = (sub_gt[0] & sub_gt[1]) | (sub_gt[0] & gt) | (sub_gt[1] & gt);
    assign res_tie = (sub_eq[0] & sub_eq[1]) | (sub_eq[0] & eq) | (sub_eq[1] & eq);

    // Latch the first two sub-window results as each next sub-window starts
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sub_gt <= '0;
            sub_eq <= '0;
        end else if (first && (count == 5'd15)) begin
            sub_gt[0] <= gt;
            sub_eq[0] <= eq;
        end else if (first && (count == 5'd20)) begin
            sub_gt[1] <= gt;
            sub_eq[1] <= eq;
        end
    end
`else
    assign sub_restart = 1'b0;
    assign res_bit     = gt;
    assign res_tie     = eq;
`endif

    // Saturating oscillation counters; a sub-window restart keeps the edge seen that clock
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (cnt_clear) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (sub_restart) begin
            cnt_a <= CNT_W'(edge_a);
            cnt_b <= CNT_W'(edge_b);
        end else if (cnt_en) begin
            if (edge_a && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_W'(1);
            if (edge_b && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_W'(1);
        end
    end

    // Shift the response bit into the key; the first bit ends at the MSB
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            key     <= '0;
            tie_cnt <= '0;
        end else if (go) begin
            key     <= '0;
            tie_cnt <= '0;
        end else if (shift_now) begin
            key <= (key << 1) | KEY_BITS'(res_bit);
            if (res_tie && (tie_cnt != 8'hFF)) tie_cnt <= tie_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_ropuf_response_evaluator.sv
// tb_ropuf_response_evaluator
// Drives ring-oscillator waveforms as closed-form functions of the cycle
// number, pushes expected {tie_cnt, key} per run into a queue, and a monitor
// pops and compares whenever key_valid rises.
module tb_ropuf_response_evaluator;

    localparam int KB      = 4;
    localparam int TD      = 4;
    localparam int CW      = 8;
    localparam int BIT_CYC = 32 * TD;
    localparam int RUN_CYC = KB * BIT_CYC;

    logic          clk    = 1'b0;
    logic          clk_en = 1'b0;
    logic          Reset;
    logic          start;
    logic [7:0]    chal_in;
    logic [15:0]   ro_in;
    logic [3:0]    round;
    logic [4:0]    count;
    logic          chal_strobe;
    logic [KB-1:0] key;
    logic          key_valid;
    logic          busy;
    logic [7:0]    tie_cnt;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            run_p  = 0;
    int            half[16];
    int            phase[16];
    logic [KB+7:0] exp_q[$];
    int            strobe_q[$];
    bit            strobe_watch = 1'b0;
    logic          kv_q = 1'b0;
`ifdef ROPUF_MAJORITY_VOTE_EN
    bit            maj_mode = 1'b0;
    int            half_sub[16][3];
`endif

    ropuf_response_evaluator #(
        .KEY_BITS(KB),
        .TICK_DIV(TD),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .start      (start),
        .chal_in    (chal_in),
        .ro_in      (ro_in),
        .round      (round),
        .count      (count),
        .chal_strobe(chal_strobe),
        .key        (key),
        .key_valid  (key_valid),
        .busy       (busy),
        .tie_cnt    (tie_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 if (clk_en) clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- reference waveforms and model ----------------
    function automatic int sub_of(input int c);
        int n;
        if (c < run_p) return 0;
        n = ((c - run_p) % BIT_CYC) / TD;
        if (n < 15) return 0;
        if (n < 20) return 1;
        return 2;
    endfunction

    function automatic logic wave(input int i, input int c);
        int h;
        h = half[i];
`ifdef ROPUF_MAJORITY_VOTE_EN
        if (maj_mode) h = half_sub[i][sub_of(c)];
`endif
        if (h == 0 || c < 0) return 1'b0;
        return 1'(((c + phase[i]) / h) % 2);
    endfunction

    // Rising edges whose detection (two clocks after the input changes) falls
    // in steps first..last of the bit starting at cycle base
    function automatic int rises(input int ro, input int base, input int first, input int last);
        int n;
        n = 0;
        for (int w = base + first * TD; w < base + (last + 1) * TD; w++)
            if (wave(ro, w - 2) && !wave(ro, w - 3)) n++;
        return n;
    endfunction

    function automatic logic [KB+7:0] model_run(input int a, input int b, input int p);
        logic [KB-1:0] k;
        logic [7:0]    t;
        logic          bitv;
        logic          tie;
        int            base;
        int            gts;
        int            eqs;
        int            ea;
        int            eb;
        k = '0;
        t = '0;
        for (int bi = 0; bi < KB; bi++) begin
            base = p + bi * BIT_CYC;
`ifdef ROPUF_MAJORITY_VOTE_EN
            gts = 0;
            eqs = 0;
            for (int s = 0; s < 3; s++) begin
                ea = rises(a, base, 10 + 5 * s, 14 + 5 * s);
                eb = rises(b, base, 10 + 5 * s, 14 + 5 * s);
                if (ea > eb) gts++;
                if (ea == eb) eqs++;
            end
            bitv = (gts >= 2);
            tie  = (eqs >= 2);
`else
            gts  = 0;
            eqs  = 0;
            ea   = rises(a, base, 10, 24);
            eb   = rises(b, base, 10, 24);
            bitv = (ea > eb);
            tie  = (ea == eb);
`endif
            k = {k[KB-2:0], bitv};
            if (tie && t != 8'hFF) t = t + 8'd1;
        end
        return {t, k};
    endfunction

    // ---------------- RO driver ----------------
    initial begin
        ro_in = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 16; i++) ro_in[i] = wave(i, cyc);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [KB+7:0] e;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1 && kv_q !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_result key=%0h tie=%0d", key, tie_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_key", 32'(key), 32'(e[KB-1:0]));
                    check("sb_tie_cnt", 32'(tie_cnt), 32'(e[KB+7:KB]));
                end
            end
            kv_q = key_valid;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (strobe_watch && chal_strobe === 1'b1) strobe_q.push_back(cyc - run_p);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [7:0] ch, input bit use_model, input logic [KB+7:0] fixed);
        @(negedge clk);
        chal_in = ch;
        start   = 1'b1;
        run_p   = cyc + 1;
        if (use_model) exp_q.push_back(model_run(int'(ch[7:4]), int'(ch[3:0]), run_p));
        else           exp_q.push_back(fixed);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        int n;
        int sc;
        n = 0;
        while (key_valid !== 1'b1 && n < RUN_CYC + 64) begin
            @(negedge clk);
            n++;
        end
        if (key_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout key_valid=%b after %0d cycles", key_valid, n);
        end else begin
            check("done_latency", 32'(cyc - run_p), 32'(RUN_CYC));
            sc = 0;
            repeat (6) begin
                @(negedge clk);
                if (chal_strobe) sc++;
            end
            check("done_count", 32'(count), 32'd0);
            check("done_round", 32'(round), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("done_no_strobe", 32'(sc), 32'd0);
        end
    endtask

    task automatic randomize_ros();
        for (int i = 0; i < 16; i++) begin
            half[i]  = int'($urandom_range(12, 2));
            phase[i] = int'($urandom_range(31, 0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [7:0] ch;
        int a;
        int b;
        Reset   = 1'b0;
        start   = 1'b0;
        chal_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            half[i]  = 0;
            phase[i] = 0;
        end
        #1 Reset = 1'b1;
        #2;
        // Reset values with no clock running
        check("rst_key", 32'(key), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chal_strobe", 32'(chal_strobe), 32'd0);
        check("rst_round", 32'(round), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tie_cnt", 32'(tie_cnt), 32'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic compare: RO3 twice as fast as RO10, unselected ROs toggling randomly
        randomize_ros();
        half[3]   = 4;  phase[3]  = 0;
        half[10]  = 8;  phase[10] = 0;
        start_run(8'h3A, 1'b0, {8'd0, 4'b1111});
        wait_done();

        // Swapped pair, restarted straight from DONE
        start_run(8'hA3, 1'b0, {8'd0, 4'b0000});
        wait_done();

        // Tie: identical waveforms; also record the challenge strobes
        half[10] = 4;
        strobe_q.delete();
        strobe_watch = 1'b1;
        start_run(8'h3A, 1'b0, {8'd4, 4'b0000});
        wait_done();
        strobe_watch = 1'b0;
        check("strobe_total", 32'(strobe_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < strobe_q.size())
                check("strobe_cycle", 32'(strobe_q[i]),
                      32'((i == 0) ? 5 * TD : i * BIT_CYC + 26 * TD));
        end

        // Reset in the middle of bit 2, then a clean rerun
        half[10] = 8;
        start_run(8'h3A, 1'b0, {8'd0, 4'b1111});
        while (cyc < run_p + 2 * BIT_CYC + 17 * TD) @(negedge clk);
        check("midrun_count", 32'(count), 32'd17);
        Reset = 1'b1;
        #1;
        check("midrun_rst_key", 32'(key), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_count", 32'(count), 32'd0);
        check("midrun_rst_tie", 32'(tie_cnt), 32'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        Reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_valid", 32'(key_valid), 32'd0);
        start_run(8'h3A, 1'b0, {8'd0, 4'b1111});
        wait_done();

        // Randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            randomize_ros();
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            if (b == a) b = (a + 1 + int'($urandom_range(14, 0))) % 16;
            ch = {4'(a), 4'(b)};
            start_run(ch, 1'b1, '0);
            wait_done();
        end

`ifdef ROPUF_MAJORITY_VOTE_EN
        // Majority vote: A fast in sub-windows 1 and 3, slow in 2; then reversed
        for (int i = 0; i < 16; i++)
            for (int s = 0; s < 3; s++) half_sub[i][s] = half[i];
        half_sub[3][0]  = 2;  half_sub[3][1]  = 12; half_sub[3][2]  = 2;
        half_sub[10][0] = 12; half_sub[10][1] = 2;  half_sub[10][2] = 12;
        maj_mode = 1'b1;
        start_run(8'h3A, 1'b0, {8'd0, 4'b1111});
        wait_done();
        half_sub[3][0]  = 12; half_sub[3][1]  = 2;  half_sub[3][2]  = 12;
        half_sub[10][0] = 2;  half_sub[10][1] = 12; half_sub[10][2] = 2;
        start_run(8'h3A, 1'b0, {8'd0, 4'b0000});
        wait_done();
        maj_mode = 1'b0;
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog: the whole sequence is a few thousand clocks
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog simulation did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ropuf_response_evaluator.md
# ropuf_response_evaluator

Consumer and sequencer for the RO-PUF challenge path. Drives the `round`/`count` schedule that the challenge shift register follows, and strobes it to publish each 8-bit challenge pair. Takes that pair back, counts rising edges of the two selected ring oscillators over a measurement window, compares the counts into one response bit, and shifts the bits into a key register. It sits between the 16-RO array and the AES key-expansion input.

## Interface
Parameters:
- `KEY_BITS`, 128: response bits collected per run; legal 1..256.
- `TICK_DIV`, 64: clk cycles per `count` step; legal ≥2.
- `CNT_W`, 16: width of each oscillation counter.

Ports:
- `clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a run; ignored unless in IDLE or DONE.
- `chal_in`  in  8  challenge pair; `[7:4]` selects RO A, `[3:0]` selects RO B.
- `ro_in`  in  16  raw ring-oscillator outputs, asynchronous to clk.
- `round`  out  4  `bit_idx[7:4]`.
- `count`  out  5  step within the current bit, 0..31.
- `chal_strobe`  out  1  one-clock pulse; the challenge generator latches a new pair on it.
- `key`  out  `KEY_BITS`  collected response; first bit ends up at the MSB.
- `key_valid`  out  1  high in DONE.
- `busy`  out  1  high in RUN.
- `tie_cnt`  out  8  number of bits decided by equal counts; saturates at 255.

## Operation
- States:
  - IDLE →(`start`) RUN.
  - RUN →(last bit finished) DONE.
  - DONE →(`start`) RUN.
- Entering RUN clears `key`, `tie_cnt`, `bit_idx`, `count` and the prescaler.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN.
  - `tick` asserts when the prescaler equals TICK_DIV-1.
  - On `tick`, `count` increments, wrapping 31→0.
  - On a 31→0 wrap, `bit_idx` increments.
  - If the incremented `bit_idx` equals KEY_BITS, the next state is DONE.
- Per-bit schedule, by `count`:
  - 0..9: both oscillation counters held at 0.
  - 10..24: measurement window; counters enabled.
  - 25: compare and shift.
  - 26..31: idle.
- RO path:
  - All 16 `ro_in` bits pass a 2-flop synchronizer, then a rising-edge detector.
  - Mux A selects edge `chal_in[7:4]`; mux B selects edge `chal_in[3:0]`.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Compare, on the first clock of `count`==25:
  - bit = (cntA > cntB).
  - `key` ← {`key[KEY_BITS-2:0]`, bit}.
  - If cntA == cntB: bit = 0 and `tie_cnt` increments (saturating).
- `chal_strobe`:
  - When `bit_idx`==0: pulses on the first clock of `count`==5.
  - Otherwise: pulses on the first clock of `count`==26.
  - `chal_in` must be stable from `count`==10 through 25.
- `start` while in RUN: no effect.
- In DONE: `key` holds, `count`/`round` hold 0, no strobes.

## Timing
- Reset values:
  - State = IDLE.
  - `key`=0, `key_valid`=0, `busy`=0, `chal_strobe`=0, `round`=0, `count`=0, `tie_cnt`=0.
  - Counters, prescaler and synchronizers = 0.
- Reset mid-run: immediate return to the reset values; the partial key is discarded.
- All outputs are registered. `busy` rises the clock after `start`.
- One bit takes 32·TICK_DIV clocks. A full run takes KEY_BITS·32·TICK_DIV clocks.
- `key_valid` rises on the clock after the final 31→0 wrap.
- Edge latency is 3 clocks (sync + detect). An RO edge inside the last 3 clocks of `count`==24 is not counted.
- Supported RO frequency is < clk/2.

## Configuration
- `ROPUF_MAJORITY_VOTE_EN`, defined:
  - The window is split into three sub-windows: `count` 10..14, 15..19 and 20..24.
  - Counters clear at the start of each sub-window.
  - A sub-bit is latched at the first clock of 15, 20 and 25 (the last one before the shift).
  - The shifted bit is the majority of the three sub-bits.
  - `tie_cnt` increments only if at least 2 of the 3 sub-windows tied.
- Undefined: single window 10..24, as described in Operation.

## Test plan
All scenarios use bench parameters KEY_BITS=4, TICK_DIV=4.

- **Reset:** assert `Reset` with no clock.
  - Required: all outputs 0; IDLE; `start` 20 clocks later gives `busy`=1 on the next clock.
- **Basic compare:** `chal_in`=8'h3A; RO3 toggles every 4 clk, RO10 every 8 clk; all four bits.
  - Required: `key`=4'b1111, `tie_cnt`=0, `key_valid` at clock 512+1.
- **Swapped pair:** `chal_in`=8'hA3 with the same oscillators.
  - Required: `key`=4'b0000, `tie_cnt`=0.
- **Tie:** RO3 and RO10 at identical rates.
  - Required: `key`=0, `tie_cnt`=4.
  - Also: `chal_strobe` pulses at the clock where `count`=5 in bit 0, then at `count`=26 in bits 1..3, 4 pulses total.
- **Reset mid-run:** assert `Reset` at `count`=17 of bit 2.
  - Required: `key`=0, `busy`=0.
  - A new `start` completes normally, matching the basic-compare result.
- **Majority (`ROPUF_MAJORITY_VOTE_EN`):** RO A faster in sub-windows 1 and 3, slower in sub-window 2.
  - Required: bit=1.
  - Reversing the pattern gives bit=0.
